// File: rtl/ship_lock_ctrl_pkg.sv
// Shared definitions for the ship damage/lock controller.
// State encoding is fixed so ship control and display blocks can decode it.
package ship_lock_ctrl_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_LOCKED = 2'd2
    } ship_state_e;

endpackage : ship_lock_ctrl_pkg

// File: rtl/ship_lock_ctrl_down_timer.sv
// down_timer: loadable down counter that stops at zero.
// A load has priority over a decrement; zero reflects the stored count.
module down_timer #(
    parameter int TMR_W = 27
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic [TMR_W-1:0] cnt,
    output logic             zero
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    // Next count: load wins, otherwise count down while enabled and non-zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule : down_timer

// File: rtl/ship_lock_ctrl.sv
// ship_lock_ctrl: counts hits, locks the ship after N of them, opens an
// invulnerability window after each non-fatal hit and restores on revive.
// Optional build macro SHIP_LOCK_REGEN_EN: while ALIVE with damage, every
// REGEN_CYCLES consecutive hit-free cycles heal one hit.
module ship_lock_ctrl
    import ship_lock_ctrl_pkg::*;
#(
    parameter int CNT_W         = 4,
    parameter int N             = 3,
    parameter int INVULN_CYCLES = 16,
    parameter int TMR_W         = 27,
    parameter int REGEN_CYCLES  = 64
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic             hit,
    input  logic             revive,
    output logic             unlocked_signal,
    output logic [CNT_W-1:0] hit_counter,
    output logic             invuln
);

    localparam logic [CNT_W-1:0] N_L      = CNT_W'(N);
    localparam logic [TMR_W-1:0] INV_LOAD =
        (INVULN_CYCLES > 0) ? TMR_W'(INVULN_CYCLES - 1) : '0;
    localparam logic [TMR_W-1:0] REGEN_LOAD =
        (REGEN_CYCLES > 0) ? TMR_W'(REGEN_CYCLES - 1) : '0;
    localparam bit HAS_WINDOW = (INVULN_CYCLES > 0);

    ship_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unlocked_q, unlocked_d;
    logic             invuln_q, invuln_d;

    // Invulnerability window timer controls
    logic             inv_load;
    logic [TMR_W-1:0] inv_load_val;
    logic             inv_en;
    logic             inv_zero;
    logic [TMR_W-1:0] inv_cnt_unused;

    down_timer #(
        .TMR_W (TMR_W)
    ) u_inv_timer (
        .clk      (pclk),
        .rst      (rst),
        .load     (inv_load),
        .load_val (inv_load_val),
        .en       (inv_en),
        .cnt      (inv_cnt_unused),
        .zero     (inv_zero)
    );

`ifdef SHIP_LOCK_REGEN_EN
    // Regen timer: counts hit-free ALIVE cycles while damaged; held at its
    // reload value whenever it is not running so each run starts fresh.
    logic             regen_run;
    logic             regen_load;
    logic             regen_zero;
    logic [TMR_W-1:0] regen_cnt_unused;

    // Regen runs only in ALIVE with damage and no hit/revive this cycle.
    always_comb begin
        regen_run  = (state_q == ST_ALIVE) && (cnt_q != '0) && !hit && !revive;
        regen_load = !regen_run || regen_zero;
    end

    down_timer #(
        .TMR_W (TMR_W)
    ) u_regen_timer (
        .clk      (pclk),
        .rst      (rst),
        .load     (regen_load),
        .load_val (REGEN_LOAD),
        .en       (regen_run),
        .cnt      (regen_cnt_unused),
        .zero     (regen_zero)
    );
`else
    // REGEN_CYCLES has no effect in this build.
    logic [TMR_W-1:0] regen_load_unused;
    assign regen_load_unused = REGEN_LOAD;
`endif

    // FSM and hit counter next-state; revive overrides everything.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        inv_load     = 1'b0;
        inv_load_val = '0;
        inv_en       = 1'b0;

        if (revive) begin
            state_d      = ST_ALIVE;
            cnt_d        = '0;
            inv_load     = 1'b1;
            inv_load_val = '0;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (hit) begin
                        cnt_d = (&cnt_q) ? cnt_q : (cnt_q + CNT_W'(1));
                        if (cnt_d >= N_L) begin
                            state_d = ST_LOCKED;
                        end else if (HAS_WINDOW) begin
                            state_d      = ST_INVULN;
                            inv_load     = 1'b1;
                            inv_load_val = INV_LOAD;
                        end
                    end
`ifdef SHIP_LOCK_REGEN_EN
                    else if (regen_run && regen_zero) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
`endif
                end
                ST_INVULN: begin
                    // Hits are ignored; the timer reaching zero ends the window.
                    inv_en = 1'b1;
                    if (inv_zero) begin
                        state_d = ST_ALIVE;
                    end
                end
                ST_LOCKED: begin
                    state_d = ST_LOCKED;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end

        unlocked_d = (cnt_d < N_L);
        invuln_d   = (state_d == ST_INVULN);
    end

    // State, counter and registered outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= ST_ALIVE;
            cnt_q      <= '0;
            unlocked_q <= 1'b0;
            invuln_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            unlocked_q <= unlocked_d;
            invuln_q   <= invuln_d;
        end
    end

    assign unlocked_signal = unlocked_q;
    assign hit_counter     = cnt_q;
    assign invuln          = invuln_q;

endmodule : ship_lock_ctrl

// File: tb/tb_ship_lock_ctrl.sv
// Directed testbench for ship_lock_ctrl (N=3, CNT_W=4, INVULN_CYCLES=4, REGEN_CYCLES=8).
module tb_ship_lock_ctrl;

    localparam int CNT_W = 4;
    localparam int N     = 3;
    localparam int INV   = 4;
    localparam int TMR_W = 8;
    localparam int REGEN = 8;
`ifdef SHIP_LOCK_REGEN_EN
    localparam bit REGEN_ON = 1'b1;
`else
    localparam bit REGEN_ON = 1'b0;
`endif

    logic             pclk = 1'b0;
    logic             rst;
    logic             hit;
    logic             revive;
    logic             unlocked_signal;
    logic [CNT_W-1:0] hit_counter;
    logic             invuln;

    int n_checks = 0;
    int n_pass   = 0;

    ship_lock_ctrl #(
        .CNT_W         (CNT_W),
        .N             (N),
        .INVULN_CYCLES (INV),
        .TMR_W         (TMR_W),
        .REGEN_CYCLES  (REGEN)
    ) dut (
        .pclk            (pclk),
        .rst             (rst),
        .hit             (hit),
        .revive          (revive),
        .unlocked_signal (unlocked_signal),
        .hit_counter     (hit_counter),
        .invuln          (invuln)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("check %s: got %0d", tag, got);
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges; return 1 time unit after the last edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic chk_all(input string tag, input int exp_unl, input int exp_cnt, input int exp_inv);
        chk({tag, ".unlocked"}, int'(unlocked_signal), exp_unl);
        chk({tag, ".cnt"},      int'(hit_counter),     exp_cnt);
        chk({tag, ".invuln"},   int'(invuln),          exp_inv);
    endtask

    initial begin
        rst    = 1'b1;
        hit    = 1'b0;
        revive = 1'b0;

        // Reset for 3 cycles, then release.
        tick(3);
        chk_all("reset", 0, 0, 0);
        rst = 1'b0;
        tick(1);
        chk_all("release", 1, 0, 0);

        // Single hit: window of exactly 4 cycles; hit inside window ignored.
        hit = 1'b1; tick(1); hit = 1'b0;
        chk_all("hit1_e0", 1, 1, 1);
        tick(1);
        chk("win_e1", int'(invuln), 1);
        hit = 1'b1; tick(1); hit = 1'b0;
        chk_all("win_e2_hit_ignored", 1, 1, 1);
        tick(1);
        chk("win_e3", int'(invuln), 1);
        tick(1);
        chk_all("win_end_e4", 1, 1, 0);

        // Regen: 8 hit-free ALIVE cycles after the window heals one hit.
        tick(7);
        chk("regen_e11", int'(hit_counter), 1);
        tick(1);
        chk("regen_e12", int'(hit_counter), REGEN_ON ? 0 : 1);

        revive = 1'b1; tick(1); revive = 1'b0;
        chk_all("revive_clean", 1, 0, 0);

        // Three hits spaced 6 cycles lock the ship.
        for (int k = 1; k <= 3; k++) begin
            hit = 1'b1; tick(1); hit = 1'b0;
            chk_all($sformatf("hit_seq%0d", k), (k < 3) ? 1 : 0, k, (k < 3) ? 1 : 0);
            if (k < 3) tick(5);
        end
        hit = 1'b1; tick(1); hit = 1'b0;
        chk_all("locked_hit", 0, 3, 0);
        hit = 1'b1; tick(1); hit = 1'b0;
        tick(12);
        chk_all("locked_hold", 0, 3, 0);

        // Hit and revive in the same cycle while locked: revive wins.
        hit = 1'b1; revive = 1'b1; tick(1); hit = 1'b0; revive = 1'b0;
        chk_all("revive_beats_hit", 1, 0, 0);

        // Reset in the middle of the invulnerability window.
        hit = 1'b1; tick(1); hit = 1'b0;
        chk_all("pre_rst_hit", 1, 1, 1);
        tick(1);
        rst = 1'b1; tick(1);
        chk_all("rst_mid_window", 0, 0, 0);
        rst = 1'b0; tick(1);
        chk_all("rst_mid_release", 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_all($sformatf("post_rst%0d", i), 1, 0, 0);
        end

        // Revive inside the window returns to ALIVE; next hit opens a new window.
        hit = 1'b1; tick(1); hit = 1'b0;
        tick(1);
        revive = 1'b1; tick(1); revive = 1'b0;
        chk_all("revive_in_window", 1, 0, 0);
        hit = 1'b1; tick(1); hit = 1'b0;
        chk_all("hit_after_revive", 1, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ship_lock_ctrl
